cav_relock: RTL and testbench
=============================

Name: cav_relock

Overview:
Lock-acquisition and relock sequencer that drives the control inputs of the fast cavity PID servo and reads back the loop's state.
- Sweeps the cavity actuator with a triangle ramp until transmission crosses a threshold, then enables the PID.
- Declares lock after a settle time and monitors transmission and PID output railing.
- On lock loss it disables the PID and resumes sweeping, counting relock events.
- Sits between cavity transmission pickup, PID (on/hld inputs, s_out readback) and the actuator summing stage.

Parameters:
FILTER_IO_SIZE, 25, word length of transmission, thresholds, PID output, limits and sweep values.
CNT_W, 24, width of settle and loss timers.

Ports:
clk  in  1  system clock, 100 MHz.
rst_n  in  1  synchronous, active-low reset.
en  in  1  sequencer enable.
trans  in  signed FILTER_IO_SIZE  cavity transmission.
thr_lock  in  signed FILTER_IO_SIZE  transmission level that triggers catch.
thr_lost  in  signed FILTER_IO_SIZE  transmission level below which lock is failing (thr_lost <= thr_lock).
pid_out  in  signed FILTER_IO_SIZE  PID output readback.
LL, UL  in  signed FILTER_IO_SIZE  PID limits, used for rail detection.
sw_lo, sw_hi  in  signed FILTER_IO_SIZE  sweep bounds.
sw_step  in  FILTER_IO_SIZE unsigned  sweep increment per step.
NSW  in  5  sweep divider: one step every 2^NSW clocks.
t_settle  in  CNT_W  cycles in CATCH before LOCKED.
t_lost  in  CNT_W  consecutive bad cycles in LOCKED before loss is declared.
pid_on  out  1  PID enable.
pid_hld  out  1  PID integrator hold.
sweep_out  out  signed FILTER_IO_SIZE  actuator offset.
locked  out  1  high in LOCKED.
state  out  3  IDLE=0, SWEEP=1, CATCH=2, LOCKED=3, LOST=4.
relock_cnt  out  16  number of LOST entries.

Behaviour:
- All outputs are registered. Conditions are evaluated on the current-cycle inputs; the response appears on the next clock edge.
- Reset (rst_n=0 at clk edge): state=IDLE, pid_on=0, pid_hld=0, sweep_out=0, locked=0, relock_cnt=0, dir=up, divider=0, timers=0. Reset mid-operation aborts immediately with these values.
- en=0 in any state: IDLE on the next edge. This has priority over every other transition. relock_cnt is retained.
- IDLE: pid_on=0, sweep_out=sw_lo. en=1 -> SWEEP, dir=up, divider=0.
- SWEEP:
  - pid_on=0.
  - The divider counts 0..2^NSW-1; on wrap, sweep_out += sw_step (dir up) or -= sw_step (dir down).
  - Sum is computed in FILTER_IO_SIZE+2 bits and clamped to [sw_lo, sw_hi]. Reaching a bound reverses dir.
  - If sw_lo >= sw_hi, sweep_out holds sw_lo.
  - trans >= thr_lock -> CATCH. sweep_out is frozen and the timer is cleared.
- CATCH:
  - pid_on=1, timer increments each cycle.
  - trans < thr_lost -> SWEEP with pid_on=0; the ramp resumes from the frozen value with the same dir.
  - Otherwise, timer == max(t_settle,1)-1 -> LOCKED.
- LOCKED:
  - pid_on=1, locked=1, sweep_out frozen.
  - bad = (trans < thr_lost) OR (pid_out >= UL) OR (pid_out <= LL).
  - The bad counter increments while bad and clears when not bad.
  - Counter reaching max(t_lost,1)-1 while bad -> LOST.
- LOST: exactly one cycle. pid_on=0, locked=0, relock_cnt += 1 (saturates at 16'hFFFF) -> SWEEP, divider=0, dir kept.
- Simultaneous catch condition and bound reversal in SWEEP: CATCH wins; dir is still updated.

Optional Feature:
CAV_RELOCK_HOLD_EN:
- Defined: in LOCKED, pid_hld=1 on the cycle after trans < thr_lost is first seen, and stays high while that condition persists. It deasserts the cycle after recovery. It is forced 0 in LOST, and in every other state.
- Undefined: pid_hld is constant 0.

Test Plan:
1. Reset with en=1, then release: state=0 for the first cycle after reset; with sw_lo=-1000 the next edge gives state=1 and sweep_out=-1000.
2. Sweep: NSW=2, sw_step=100, sw_lo=-1000, sw_hi=-700, trans=0, thr_lock=500. Sweep_out steps every 4 clocks through -900, -800, -700, then -800, -900, with reversal at each bound.
3. Catch to lock: mid-sweep set trans=600, thr_lost=200, t_settle=10. pid_on rises the next cycle, sweep_out freezes, and locked rises 10 cycles after CATCH entry.
4. Lock loss: in LOCKED with t_lost=5, drive pid_out=UL for 5 cycles. LOST is seen for 1 cycle, relock_cnt 0->1, pid_on=0, then SWEEP. With a 4-cycle bad pulse, the bench observes no loss.
5. Abort: en=0 in CATCH -> IDLE and pid_on=0 on the next edge. rst_n=0 in LOCKED -> all outputs zero, relock_cnt=0.
6. Build with CAV_RELOCK_HOLD_EN: in LOCKED set trans=100 < thr_lost=200 for 3 cycles, t_lost=8. pid_hld is high for 3 cycles, then low, with no LOST entered. Without the macro, pid_hld stays 0.

Source files
------------

// File: rtl/cav_relock.sv
// cav_relock: cavity lock-acquisition and relock sequencer for the PID servo.
// In: en, trans, thr_lock/thr_lost, pid_out, LL/UL rails, sw_lo/sw_hi/sw_step,
//     NSW divider, t_settle/t_lost timers.
// Out: pid_on, pid_hld, sweep_out, locked, state, relock_cnt (all registered).
// Build option CAV_RELOCK_HOLD_EN: hold the PID integrator while transmission
// is weak in LOCKED; without it pid_hld is tied low.
module cav_relock #(
    parameter int FILTER_IO_SIZE = 25,
    parameter int CNT_W          = 24
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             en,
    input  logic signed [FILTER_IO_SIZE-1:0] trans,
    input  logic signed [FILTER_IO_SIZE-1:0] thr_lock,
    input  logic signed [FILTER_IO_SIZE-1:0] thr_lost,
    input  logic signed [FILTER_IO_SIZE-1:0] pid_out,
    input  logic signed [FILTER_IO_SIZE-1:0] LL,
    input  logic signed [FILTER_IO_SIZE-1:0] UL,
    input  logic signed [FILTER_IO_SIZE-1:0] sw_lo,
    input  logic signed [FILTER_IO_SIZE-1:0] sw_hi,
    input  logic        [FILTER_IO_SIZE-1:0] sw_step,
    input  logic        [4:0]                NSW,
    input  logic        [CNT_W-1:0]          t_settle,
    input  logic        [CNT_W-1:0]          t_lost,
    output logic                             pid_on,
    output logic                             pid_hld,
    output logic signed [FILTER_IO_SIZE-1:0] sweep_out,
    output logic                             locked,
    output logic        [2:0]                state,
    output logic        [15:0]               relock_cnt
);

    localparam int W = FILTER_IO_SIZE;
    localparam int X = FILTER_IO_SIZE + 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SWEEP  = 3'd1,
        S_CATCH  = 3'd2,
        S_LOCKED = 3'd3,
        S_LOST   = 3'd4
    } state_t;

    state_t st_q, st_d;

    logic                on_d;
    logic                lk_d;
    logic signed [W-1:0] sw_d;
    logic        [15:0]  rc_d;
    logic                dir_q, dir_d;      // 0 = up, 1 = down
    logic        [31:0]  div_q, div_d, div_max;
    logic [CNT_W-1:0]    tmr_q, tmr_d;      // settle timer in CATCH, bad counter in LOCKED
    logic [CNT_W-1:0]    settle_m1, lost_m1;

    logic signed [X-1:0] cur_x, lo_x, hi_x, sum_x;
    logic signed [W-1:0] ramp_sw;
    logic                ramp_dir;

    logic wrap, flat, catch_c, low, bad;

    assign div_max = (32'd1 << NSW) - 32'd1;
    // >= keeps the divider from running away if NSW shrinks mid-sweep
    assign wrap    = div_q >= div_max;
    assign flat    = sw_lo >= sw_hi;
    assign catch_c = trans >= thr_lock;
    assign low     = trans < thr_lost;
    assign bad     = low || (pid_out >= UL) || (pid_out <= LL);

    assign settle_m1 = (t_settle == '0) ? '0 : t_settle - CNT_W'(1);
    assign lost_m1   = (t_lost == '0) ? '0 : t_lost - CNT_W'(1);

    // Ramp step with two guard bits so the sum cannot wrap before clamping
    assign cur_x = {{2{sweep_out[W-1]}}, sweep_out};
    assign lo_x  = {{2{sw_lo[W-1]}}, sw_lo};
    assign hi_x  = {{2{sw_hi[W-1]}}, sw_hi};
    assign sum_x = dir_q ? cur_x - $signed({2'b00, sw_step})
                         : cur_x + $signed({2'b00, sw_step});

    always_comb begin
        ramp_sw  = sum_x[W-1:0];
        ramp_dir = dir_q;
        if (sum_x >= hi_x) begin
            ramp_sw  = sw_hi;
            ramp_dir = 1'b1;
        end else if (sum_x <= lo_x) begin
            ramp_sw  = sw_lo;
            ramp_dir = 1'b0;
        end
    end

    always_comb begin
        st_d  = st_q;
        sw_d  = sweep_out;
        rc_d  = relock_cnt;
        dir_d = dir_q;
        div_d = '0;
        tmr_d = '0;
        on_d  = 1'b0;
        lk_d  = 1'b0;
        unique case (st_q)
            S_IDLE: begin
                sw_d  = sw_lo;
                dir_d = 1'b0;
                if (en) st_d = S_SWEEP;
            end
            S_SWEEP: begin
                div_d = wrap ? '0 : div_q + 32'd1;
                // direction follows the ramp even when catch freezes it
                if (!flat && wrap) dir_d = ramp_dir;
                if (catch_c) begin
                    st_d  = S_CATCH;
                    div_d = '0;
                end else if (flat) begin
                    sw_d = sw_lo;
                end else if (wrap) begin
                    sw_d = ramp_sw;
                end
            end
            S_CATCH: begin
                if (low) begin
                    st_d = S_SWEEP;
                end else if (tmr_q >= settle_m1) begin
                    st_d = S_LOCKED;
                end else begin
                    tmr_d = tmr_q + CNT_W'(1);
                end
            end
            S_LOCKED: begin
                if (bad) begin
                    if (tmr_q >= lost_m1) begin
                        st_d = S_LOST;
                        rc_d = (relock_cnt == 16'hFFFF) ? relock_cnt
                                                        : relock_cnt + 16'd1;
                    end else begin
                        tmr_d = tmr_q + CNT_W'(1);
                    end
                end
            end
            S_LOST:  st_d = S_SWEEP;
            default: st_d = S_IDLE;
        endcase
        if (!en) begin
            st_d  = S_IDLE;
            sw_d  = sw_lo;
            rc_d  = relock_cnt;
            dir_d = 1'b0;
            div_d = '0;
            tmr_d = '0;
        end
        on_d = (st_d == S_CATCH) || (st_d == S_LOCKED);
        lk_d = (st_d == S_LOCKED);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q       <= S_IDLE;
            pid_on     <= 1'b0;
            locked     <= 1'b0;
            sweep_out  <= '0;
            relock_cnt <= '0;
            dir_q      <= 1'b0;
            div_q      <= '0;
            tmr_q      <= '0;
        end else begin
            st_q       <= st_d;
            pid_on     <= on_d;
            locked     <= lk_d;
            sweep_out  <= sw_d;
            relock_cnt <= rc_d;
            dir_q      <= dir_d;
            div_q      <= div_d;
            tmr_q      <= tmr_d;
        end
    end

`ifdef CAV_RELOCK_HOLD_EN
    logic hld_d;

    assign hld_d = low && (st_q == S_LOCKED) && (st_d == S_LOCKED);

    always_ff @(posedge clk) begin
        if (!rst_n) pid_hld <= 1'b0;
        else        pid_hld <= hld_d;
    end
`else
    assign pid_hld = 1'b0;
`endif

    assign state = st_q;

endmodule

// File: tb/tb_cav_relock.sv
// tb_cav_relock: directed table, corner sequences and randomized run
// against an integer reference model of the relock sequencer.
module tb_cav_relock;

    localparam int W  = 25;
    localparam int CW = 24;
`ifdef CAV_RELOCK_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n, en;
    logic signed [W-1:0] trans, thr_lock, thr_lost, pid_out, LL, UL;
    logic signed [W-1:0] sw_lo, sw_hi;
    logic        [W-1:0] sw_step;
    logic        [4:0]   NSW;
    logic       [CW-1:0] t_settle, t_lost;
    logic                pid_on, pid_hld, locked;
    logic signed [W-1:0] sweep_out;
    logic        [2:0]   state;
    logic        [15:0]  relock_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cav_relock #(.FILTER_IO_SIZE(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .trans(trans),
        .thr_lock(thr_lock), .thr_lost(thr_lost), .pid_out(pid_out),
        .LL(LL), .UL(UL), .sw_lo(sw_lo), .sw_hi(sw_hi), .sw_step(sw_step),
        .NSW(NSW), .t_settle(t_settle), .t_lost(t_lost),
        .pid_on(pid_on), .pid_hld(pid_hld), .sweep_out(sweep_out),
        .locked(locked), .state(state), .relock_cnt(relock_cnt)
    );

    // Reference model: plain integers, direction as +1/-1
    int     m_st = 0, m_sw = 0, m_dir = 1, m_tmr = 0, m_rc = 0;
    longint m_div = 0;
    bit     m_on = 0, m_lk = 0, m_hld = 0;

    task automatic mdl_step();
        int st, sw, dir, tmr, rc, lo, hi, tr, po, nx, lim;
        longint div, per;
        bit hit, b;
        st = m_st; sw = m_sw; dir = m_dir; tmr = m_tmr; rc = m_rc; div = m_div;
        lo = int'(sw_lo); hi = int'(sw_hi); tr = int'(trans); po = int'(pid_out);
        per = longint'(1) << NSW;
        if (!rst_n) begin
            st = 0; sw = 0; dir = 1; tmr = 0; rc = 0; div = 0;
        end else if (!en) begin
            st = 0; sw = lo; dir = 1; tmr = 0; div = 0;
        end else begin
            case (m_st)
                0: begin st = 1; sw = lo; dir = 1; div = 0; end
                1: begin
                    hit = tr >= int'(thr_lock);
                    nx  = sw;
                    if (lo >= hi) nx = lo;
                    else if (div >= per - 1) begin
                        nx = sw + dir * int'(sw_step);
                        if (nx >= hi) begin nx = hi; dir = -1; end
                        else if (nx <= lo) begin nx = lo; dir = 1; end
                    end
                    div = (div >= per - 1) ? 0 : div + 1;
                    if (hit) begin st = 2; tmr = 0; div = 0; end
                    else sw = nx;
                end
                2: begin
                    lim = (t_settle == 0) ? 0 : int'(t_settle) - 1;
                    if (tr < int'(thr_lost)) begin st = 1; tmr = 0; div = 0; end
                    else if (tmr >= lim) begin st = 3; tmr = 0; end
                    else tmr++;
                end
                3: begin
                    lim = (t_lost == 0) ? 0 : int'(t_lost) - 1;
                    b = tr < int'(thr_lost) || po >= int'(UL) || po <= int'(LL);
                    if (!b) tmr = 0;
                    else if (tmr >= lim) begin
                        st = 4; tmr = 0;
                        if (rc < 65535) rc++;
                    end else tmr++;
                end
                default: begin st = 1; div = 0; end
            endcase
        end
        m_hld = HOLD && m_st == 3 && st == 3 && tr < int'(thr_lost);
        m_st = st; m_sw = sw; m_dir = dir; m_tmr = tmr; m_rc = rc; m_div = div;
        m_on = (st == 2) || (st == 3);
        m_lk = (st == 3);
    endtask

    task automatic tick(int n);
        for (int i = 0; i < n; i++) begin
            mdl_step();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(string nm, logic signed [63:0] act, logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    typedef struct {
        int n; bit en; int tr; int po;
        int st; int sw; bit on; bit lk; int rc;
    } vec_t;

    vec_t tbl[$];

    task automatic add(int n, bit e, int tr, int po,
                       int st, int sw, bit on, bit lk, int rc);
        vec_t v;
        v.n = n; v.en = e; v.tr = tr; v.po = po;
        v.st = st; v.sw = sw; v.on = on; v.lk = lk; v.rc = rc;
        tbl.push_back(v);
    endtask

    initial begin
        logic [46:0] ev, av;
        int pick;
        rst_n = 1'b0; en = 1'b1; trans = '0; pid_out = '0;
        thr_lock = W'(500); thr_lost = W'(200);
        LL = -W'(5000); UL = W'(5000);
        sw_lo = -W'(1000); sw_hi = -W'(700); sw_step = W'(100);
        NSW = 5'd2; t_settle = CW'(10); t_lost = CW'(5);

        // sweep, reversal, catch, lock, loss, relock and abort
        add(1, 1,   0,    0, 1, -1000, 0, 0, 0);
        add(3, 1,   0,    0, 1, -1000, 0, 0, 0);
        add(1, 1,   0,    0, 1,  -900, 0, 0, 0);
        add(4, 1,   0,    0, 1,  -800, 0, 0, 0);
        add(4, 1,   0,    0, 1,  -700, 0, 0, 0);
        add(4, 1,   0,    0, 1,  -800, 0, 0, 0);
        add(4, 1,   0,    0, 1,  -900, 0, 0, 0);
        add(2, 1,   0,    0, 1,  -900, 0, 0, 0);
        add(1, 1, 600,    0, 2,  -900, 1, 0, 0);
        add(9, 1, 600,    0, 2,  -900, 1, 0, 0);
        add(1, 1, 600,    0, 3,  -900, 1, 1, 0);
        add(4, 1, 600, 5000, 3,  -900, 1, 1, 0);
        add(1, 1, 600,    0, 3,  -900, 1, 1, 0);
        add(4, 1, 600, 5000, 3,  -900, 1, 1, 0);
        add(1, 1, 600, 5000, 4,  -900, 0, 0, 1);
        add(1, 1,   0,    0, 1,  -900, 0, 0, 1);
        add(3, 1,   0,    0, 1,  -900, 0, 0, 1);
        add(1, 1,   0,    0, 1, -1000, 0, 0, 1);
        add(4, 1,   0,    0, 1,  -900, 0, 0, 1);
        add(1, 1, 600,    0, 2,  -900, 1, 0, 1);
        add(1, 1, 150,    0, 1,  -900, 0, 0, 1);
        add(3, 1,   0,    0, 1,  -900, 0, 0, 1);
        add(1, 1,   0,    0, 1,  -800, 0, 0, 1);
        add(1, 1, 600,    0, 2,  -800, 1, 0, 1);
        add(1, 0, 600,    0, 0, -1000, 0, 0, 1);
        add(1, 1,   0,    0, 1, -1000, 0, 0, 1);
        add(3, 1,   0,    0, 1, -1000, 0, 0, 1);
        add(1, 1,   0,    0, 1,  -900, 0, 0, 1);
        add(4, 1,   0,    0, 1,  -800, 0, 0, 1);
        add(3, 1,   0,    0, 1,  -800, 0, 0, 1);
        add(1, 1, 600,    0, 2,  -800, 1, 0, 1);
        add(1, 1, 150,    0, 1,  -800, 0, 0, 1);
        add(3, 1,   0,    0, 1,  -800, 0, 0, 1);
        add(1, 1,   0,    0, 1,  -900, 0, 0, 1);

        tick(2);
        chk("rst.state", state, 0);
        chk("rst.sweep", sweep_out, 0);
        chk("rst.pid_on", pid_on, 0);
        chk("rst.locked", locked, 0);
        chk("rst.relock", relock_cnt, 0);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            en      = tbl[i].en;
            trans   = W'(tbl[i].tr);
            pid_out = W'(tbl[i].po);
            tick(tbl[i].n);
            chk($sformatf("v%0d.state", i), state, tbl[i].st);
            chk($sformatf("v%0d.sweep", i), sweep_out, tbl[i].sw);
            chk($sformatf("v%0d.pid_on", i), pid_on, tbl[i].on);
            chk($sformatf("v%0d.locked", i), locked, tbl[i].lk);
            chk($sformatf("v%0d.relock", i), relock_cnt, tbl[i].rc);
        end

        // integrator hold on a short transmission dip
        trans = W'(600);
        tick(1);
        tick(10);
        chk("hld.lock", state, 3);
        t_lost = CW'(8);
        trans  = W'(100);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk($sformatf("hld.hi%0d", i), pid_hld, HOLD);
        end
        trans = W'(600);
        tick(1);
        chk("hld.lo", pid_hld, 0);
        chk("hld.state", state, 3);

        // reset while locked
        rst_n = 1'b0;
        tick(1);
        chk("rstl.state", state, 0);
        chk("rstl.sweep", sweep_out, 0);
        chk("rstl.pid_on", pid_on, 0);
        chk("rstl.locked", locked, 0);
        chk("rstl.relock", relock_cnt, 0);
        chk("rstl.hld", pid_hld, 0);

        // zero timers behave as one cycle
        rst_n = 1'b1; trans = '0; t_settle = '0; t_lost = '0;
        tick(1);
        trans = W'(600);
        tick(1);
        chk("t0.catch", state, 2);
        tick(1);
        chk("t0.lock", state, 3);
        pid_out = -W'(5000);
        tick(1);
        chk("t0.lost", state, 4);
        chk("t0.relock", relock_cnt, 1);
        pid_out = '0; trans = '0;
        tick(1);
        chk("t0.sweep", state, 1);

        // degenerate sweep window
        sw_lo = -W'(500); sw_hi = -W'(600);
        tick(10);
        chk("flat.sweep", sweep_out, -500);
        chk("flat.state", state, 1);

        // randomized run against the model
        for (int c = 0; c < 3000; c++) begin
            if (c % 300 == 0) begin
                rst_n    = 1'b0;
                NSW      = 5'($urandom_range(0, 2));
                sw_lo    = W'(int'($urandom_range(0, 200)) - 1000);
                sw_hi    = W'(int'(sw_lo) + int'($urandom_range(0, 450)) - 50);
                sw_step  = W'($urandom_range(50, 150));
                t_settle = CW'($urandom_range(0, 5));
                t_lost   = CW'($urandom_range(0, 4));
            end else begin
                rst_n = 1'b1;
            end
            en = ($urandom_range(0, 63) != 0);
            if ($urandom_range(0, 3) == 0) begin
                pick = int'($urandom_range(0, 4));
                case (pick)
                    0:       trans = '0;
                    1:       trans = W'(100);
                    2:       trans = W'(300);
                    default: trans = W'(600);
                endcase
            end
            pick = int'($urandom_range(0, 15));
            case (pick)
                0:       pid_out = W'(5000);
                1:       pid_out = -W'(5000);
                2:       pid_out = W'(4999);
                default: pid_out = '0;
            endcase
            tick(1);
            ev = {3'(m_st), 25'(m_sw), m_on, m_hld, m_lk, 16'(m_rc)};
            av = {state, sweep_out, pid_on, pid_hld, locked, relock_cnt};
            chk($sformatf("rand%0d", c), av, ev);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
